// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, one outstanding imem read, decode handshake
module instr_fetch_unit #(
  parameter int                  PC_WIDTH    = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]          HALT_OPCODE = 4'd15
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [9:0]          imem_rdata,
  input  logic                branch_valid,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [3:0]          opcode,
  output logic [3:0]          read_i1_write_i,
  output logic [4:0]          five_to_one,
  output logic [5:0]          read_i2_write_d,
  output logic [1:0]          one_to_zero,
  output logic                bit0,
  output logic                halted
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]          state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] redir_tgt;
  logic                redir_pend;
  logic                started;
  logic [9:0]          instr;
  logic                fetch_done;

  // started holds imem_req low for the first cycle after reset is released
  assign imem_req    = (state == S_FETCH) && started;
  assign imem_addr   = pc;
  assign fetch_done  = imem_req && imem_ack;
  assign instr_valid = (state == S_FULL);
  assign halted      = (state == S_HALT);

  assign opcode          = instr[9:6];
  assign read_i1_write_i = instr[5:2];
  assign five_to_one     = instr[5:1];
  assign read_i2_write_d = instr[5:0];
  assign one_to_zero     = instr[1:0];
  assign bit0            = instr[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      pc_out     <= '0;
      instr      <= '0;
      redir_pend <= 1'b0;
      redir_tgt  <= '0;
      started    <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        S_FETCH: begin
          if (fetch_done) begin
            // A redirect seen during this request turns the returned word into a discard
            if (branch_valid) begin
              pc <= branch_target;
            end else if (redir_pend) begin
              pc <= redir_tgt;
            end else begin
              instr  <= imem_rdata;
              pc_out <= pc;
              pc     <= pc + PC_ONE;
              state  <= S_FULL;
            end
            redir_pend <= 1'b0;
          end else if (branch_valid) begin
            redir_pend <= 1'b1;
            redir_tgt  <= branch_target;
          end
        end
        S_FULL: begin
          if (branch_valid) begin
            pc    <= branch_target;
            state <= S_FETCH;
          end else if (instr_ready) begin
            state <= (opcode == HALT_OPCODE) ? S_HALT : S_FETCH;
          end
        end
        S_HALT: begin
          if (branch_valid) begin
            pc    <= branch_target;
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
